// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared types for the program loader: FSM state encoding, error cause
//   codes and the byte-index to byte-lane mapping used by the assembler.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OVERRUN  = 2'b01;
  localparam logic [1:0] ERR_ADDR_OVF = 2'b10;

  // Lane that receives the k-th byte of a word (of nb bytes).
  function automatic int lane_of(input int k, input int nb, input bit lsb_first);
    if (lsb_first) begin
      return k;
    end else begin
      return nb - k - 32'sd1;
    end
  endfunction

endpackage

// File: rtl/prog_loader_asm.sv
// prog_loader_asm
//   Byte-to-word assembler. Steers each accepted byte into its lane, tracks
//   how many bytes of the current word are held and discards a partial word
//   after TIMEOUT_CYC idle cycles (0 disables the timeout).
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           synchronous return to reset values
//   en_i            bytes are accepted only while high
//   rx_dv_i         byte strobe
//   rx_byte_i       received byte
//   word_valid_o    combinational: this byte completes a word
//   word_o          combinational: held bytes merged with the current byte
module prog_loader_asm
  import prog_loader_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  output logic              word_valid_o,
  output logic [DATA_W-1:0] word_o
);

  localparam int NB = DATA_W / 8;
  localparam int CW = (NB > 2) ? $clog2(NB) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1'b1);
  localparam logic [TW-1:0] TMO_ZERO = TW'(1'b0);

  logic [DATA_W-1:0] hold_r;
  logic [CW-1:0]     byte_cnt_r;
  logic [TW-1:0]     tmo_cnt_r;
  logic              accept_s;
  logic              tmo_hit_s;
  logic [DATA_W-1:0] word_s;
  int                lane_s;

  assign accept_s = en_i & rx_dv_i;

  // Merge the incoming byte into its lane on top of the held bytes.
  always_comb begin
    lane_s = lane_of(int'(byte_cnt_r), NB, LSB_FIRST);
    word_s = hold_r;
    for (int i = 0; i < NB; i++) begin
      if (i == lane_s) begin
        word_s[i*8 +: 8] = rx_byte_i;
      end else begin
        word_s[i*8 +: 8] = hold_r[i*8 +: 8];
      end
    end
  end

  // A word completes on the byte arriving while the last index is pending.
  always_comb begin
    if (accept_s && (byte_cnt_r == CNT_LAST)) begin
      word_valid_o = 1'b1;
    end else begin
      word_valid_o = 1'b0;
    end
  end

  // Timeout fires only while a partial word is held and no byte arrives.
  always_comb begin
    if ((TIMEOUT_CYC > 0) && (byte_cnt_r != CNT_ZERO) && !accept_s && (tmo_cnt_r == TMO_LAST)) begin
      tmo_hit_s = 1'b1;
    end else begin
      tmo_hit_s = 1'b0;
    end
  end

  assign word_o = word_s;

  // Byte holding register, byte index and idle-cycle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_r     <= '0;
      byte_cnt_r <= CNT_ZERO;
      tmo_cnt_r  <= TMO_ZERO;
    end else if (clr_i) begin
      hold_r     <= '0;
      byte_cnt_r <= CNT_ZERO;
      tmo_cnt_r  <= TMO_ZERO;
    end else if (accept_s) begin
      hold_r    <= word_s;
      tmo_cnt_r <= TMO_ZERO;
      if (byte_cnt_r == CNT_LAST) begin
        byte_cnt_r <= CNT_ZERO;
      end else begin
        byte_cnt_r <= byte_cnt_r + CNT_ONE;
      end
    end else if (tmo_hit_s) begin
      byte_cnt_r <= CNT_ZERO;
      tmo_cnt_r  <= TMO_ZERO;
    end else if ((TIMEOUT_CYC > 0) && (byte_cnt_r != CNT_ZERO)) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
    end else begin
      tmo_cnt_r <= TMO_ZERO;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   UART-fed program loader: assembles bytes into DATA_W-bit words and writes
//   them to instruction memory over a request/grant port from a programmable
//   base address. END_WORD ends loading (done_o); overrun and address overflow
//   end it with err_o. clear_i returns from DONE/ERROR to IDLE.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   rx_dv_i, rx_byte_i   received byte and its one-cycle strobe
//   base_addr_i          start word address, taken on the first byte
//   clear_i              leave DONE/ERROR
//   gnt_i                memory accepts the pending write
//   we_o, addr_o, wdata_o  write request, word address, data
//   done_o, err_o, err_cause_o  status levels
//   word_cnt_o, csum_o   words written, mod-256 byte sum of written words
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 14,
  parameter bit                LSB_FIRST   = 1'b1,
  parameter logic [DATA_W-1:0] END_WORD    = DATA_W'(32'h00000FFF),
  parameter int                TIMEOUT_CYC = 100000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              clear_i,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_cause_o,
  output logic [ADDR_W:0]   word_cnt_o,
  output logic [7:0]        csum_o
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1'b1);

  state_e            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              we_r, we_s;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic [1:0]        cause_r, cause_s;
  logic [ADDR_W:0]   word_cnt_r, word_cnt_s;
  logic [7:0]        csum_r, csum_s;
  logic [7:0]        wsum_s;
  logic              asm_en_s;
  logic              clr_s;
  logic              word_valid_s;
  logic [DATA_W-1:0] word_s;

  // Clear is honoured only in the terminal states.
  always_comb begin
    if (clear_i && ((state_r == DONE) || (state_r == ERROR))) begin
      clr_s = 1'b1;
    end else begin
      clr_s = 1'b0;
    end
  end

  assign asm_en_s = (state_r == IDLE) || (state_r == COLLECT);

  prog_loader_asm #(
    .DATA_W      (DATA_W),
    .LSB_FIRST   (LSB_FIRST),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_asm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (clr_s),
    .en_i         (asm_en_s),
    .rx_dv_i      (rx_dv_i),
    .rx_byte_i    (rx_byte_i),
    .word_valid_o (word_valid_s),
    .word_o       (word_s)
  );

  // Byte sum of the word being written, folded into the checksum on grant.
  always_comb begin
    wsum_s = 8'd0;
    for (int i = 0; i < NB; i++) begin
      wsum_s = wsum_s + wdata_r[i*8 +: 8];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    we_s       = we_r;
    done_s     = done_r;
    err_s      = err_r;
    cause_s    = cause_r;
    word_cnt_s = word_cnt_r;
    csum_s     = csum_r;
    case (state_r)
      IDLE: begin
        if (rx_dv_i) begin
          addr_s  = base_addr_i;
          state_s = COLLECT;
        end else begin
          state_s = IDLE;
        end
      end
      COLLECT: begin
        if (word_valid_s) begin
          if (word_s == END_WORD) begin
            done_s  = 1'b1;
            state_s = DONE;
          end else begin
            we_s    = 1'b1;
            wdata_s = word_s;
            state_s = WRITE;
          end
        end else begin
          state_s = COLLECT;
        end
      end
      WRITE: begin
        // A byte during a pending write wins over a simultaneous grant.
        if (rx_dv_i) begin
          we_s    = 1'b0;
          err_s   = 1'b1;
          cause_s = ERR_OVERRUN;
          state_s = ERROR;
        end else if (gnt_i) begin
          we_s       = 1'b0;
          word_cnt_s = word_cnt_r + CNT_ONE;
          csum_s     = csum_r + wsum_s;
          if (addr_r == ADDR_MAX) begin
            err_s   = 1'b1;
            cause_s = ERR_ADDR_OVF;
            state_s = ERROR;
          end else begin
            addr_s  = addr_r + ADDR_ONE;
            state_s = COLLECT;
          end
        end else begin
          state_s = WRITE;
        end
      end
      DONE, ERROR: begin
        // addr_o deliberately holds across clear.
        if (clr_s) begin
          wdata_s    = '0;
          we_s       = 1'b0;
          done_s     = 1'b0;
          err_s      = 1'b0;
          cause_s    = ERR_NONE;
          word_cnt_s = '0;
          csum_s     = 8'd0;
          state_s    = IDLE;
        end else begin
          we_s = 1'b0;
        end
      end
      default: begin
        we_s    = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      addr_r     <= '0;
      wdata_r    <= '0;
      we_r       <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      cause_r    <= ERR_NONE;
      word_cnt_r <= '0;
      csum_r     <= 8'd0;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      we_r       <= we_s;
      done_r     <= done_s;
      err_r      <= err_s;
      cause_r    <= cause_s;
      word_cnt_r <= word_cnt_s;
      csum_r     <= csum_s;
    end
  end

  assign we_o        = we_r;
  assign addr_o      = addr_r;
  assign wdata_o     = wdata_r;
  assign done_o      = done_r;
  assign err_o       = err_r;
  assign err_cause_o = cause_r;
  assign word_cnt_o  = word_cnt_r;
  assign csum_o      = csum_r;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Directed bench for prog_loader. Three instances cover the 32-bit
//   LSB-first loader (with a short timeout), a 16-bit MSB-first loader and a
//   4-bit address space for the overflow case. Writes are logged on granted
//   cycles and compared with hand-computed values.
module tb_prog_loader;

  logic clk;
  logic rst_n;
  logic [7:0] rx_byte;

  // Instance A: DATA_W=32, ADDR_W=14, LSB first, timeout 50
  logic        dv_a, clear_a, gnt_a;
  logic [13:0] base_a, addr_a;
  logic        we_a, done_a, err_a;
  logic [31:0] wdata_a;
  logic [1:0]  cause_a;
  logic [14:0] wcnt_a;
  logic [7:0]  csum_a;

  // Instance B: DATA_W=16, MSB first, END_WORD 16'hFFFF, no timeout
  logic        dv_b, clear_b, gnt_b;
  logic [13:0] base_b, addr_b;
  logic        we_b, done_b, err_b;
  logic [15:0] wdata_b;
  logic [1:0]  cause_b;
  logic [14:0] wcnt_b;
  logic [7:0]  csum_b;

  // Instance C: DATA_W=32, ADDR_W=4
  logic        dv_c, clear_c, gnt_c;
  logic [3:0]  base_c, addr_c;
  logic        we_c, done_c, err_c;
  logic [31:0] wdata_c;
  logic [1:0]  cause_c;
  logic [4:0]  wcnt_c;
  logic [7:0]  csum_c;

  int n_chk;
  int n_fail;

  prog_loader #(.DATA_W(32), .ADDR_W(14), .LSB_FIRST(1'b1), .END_WORD(32'h00000FFF), .TIMEOUT_CYC(50)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rx_dv_i(dv_a), .rx_byte_i(rx_byte), .base_addr_i(base_a),
    .clear_i(clear_a), .gnt_i(gnt_a), .we_o(we_a), .addr_o(addr_a), .wdata_o(wdata_a),
    .done_o(done_a), .err_o(err_a), .err_cause_o(cause_a), .word_cnt_o(wcnt_a), .csum_o(csum_a)
  );

  prog_loader #(.DATA_W(16), .ADDR_W(14), .LSB_FIRST(1'b0), .END_WORD(16'hFFFF), .TIMEOUT_CYC(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rx_dv_i(dv_b), .rx_byte_i(rx_byte), .base_addr_i(base_b),
    .clear_i(clear_b), .gnt_i(gnt_b), .we_o(we_b), .addr_o(addr_b), .wdata_o(wdata_b),
    .done_o(done_b), .err_o(err_b), .err_cause_o(cause_b), .word_cnt_o(wcnt_b), .csum_o(csum_b)
  );

  prog_loader #(.DATA_W(32), .ADDR_W(4), .LSB_FIRST(1'b1), .END_WORD(32'h00000FFF), .TIMEOUT_CYC(100000)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .rx_dv_i(dv_c), .rx_byte_i(rx_byte), .base_addr_i(base_c),
    .clear_i(clear_c), .gnt_i(gnt_c), .we_o(we_c), .addr_o(addr_c), .wdata_o(wdata_c),
    .done_o(done_c), .err_o(err_c), .err_cause_o(cause_c), .word_cnt_o(wcnt_c), .csum_o(csum_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write logs: one entry per granted write cycle.
  int          wr_cnt_a;
  logic [13:0] log_addr_a [16];
  logic [31:0] log_data_a [16];
  int          wr_cnt_b;
  logic [13:0] last_addr_b;
  logic [15:0] last_data_b;
  int          wr_cnt_c;
  logic [3:0]  last_addr_c;
  logic [31:0] last_data_c;

  // Record every accepted write on each instance.
  always @(posedge clk) begin
    if (we_a && gnt_a) begin
      if (wr_cnt_a < 16) begin
        log_addr_a[wr_cnt_a] <= addr_a;
        log_data_a[wr_cnt_a] <= wdata_a;
      end
      wr_cnt_a <= wr_cnt_a + 1;
    end
    if (we_b && gnt_b) begin
      last_addr_b <= addr_b;
      last_data_b <= wdata_b;
      wr_cnt_b    <= wr_cnt_b + 1;
    end
    if (we_c && gnt_c) begin
      last_addr_c <= addr_c;
      last_data_c <= wdata_c;
      wr_cnt_c    <= wr_cnt_c + 1;
    end
  end

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send(input int d, input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    case (d)
      0:       dv_a = 1'b1;
      1:       dv_b = 1'b1;
      default: dv_c = 1'b1;
    endcase
    @(negedge clk);
    dv_a = 1'b0;
    dv_b = 1'b0;
    dv_c = 1'b0;
  endtask

  task automatic pulse_clear_a();
    @(negedge clk);
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
  endtask

  int start_wr;

  initial begin
    n_chk = 0; n_fail = 0;
    wr_cnt_a = 0; wr_cnt_b = 0; wr_cnt_c = 0;
    rst_n = 1'b0; rx_byte = 8'h00;
    dv_a = 1'b0; dv_b = 1'b0; dv_c = 1'b0;
    clear_a = 1'b0; clear_b = 1'b0; clear_c = 1'b0;
    gnt_a = 1'b0; gnt_b = 1'b0; gnt_c = 1'b0;
    base_a = 14'h0; base_b = 14'h0; base_c = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    chk_val("rst_we",    64'(we_a),    64'h0);
    chk_val("rst_addr",  64'(addr_a),  64'h0);
    chk_val("rst_wdata", 64'(wdata_a), 64'h0);
    chk_val("rst_done",  64'(done_a),  64'h0);
    chk_val("rst_err",   64'(err_a),   64'h0);
    chk_val("rst_cause", 64'(cause_a), 64'h0);
    chk_val("rst_wcnt",  64'(wcnt_a),  64'h0);
    chk_val("rst_csum",  64'(csum_a),  64'h0);

    // Basic load: two words then END_WORD
    base_a = 14'h010;
    gnt_a  = 1'b1;
    send(0, 8'h13); send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
    send(0, 8'h93); send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
    send(0, 8'hFF); send(0, 8'h0F); send(0, 8'h00); send(0, 8'h00);
    repeat (3) @(negedge clk);
    chk_val("t1_nwr",   64'(wr_cnt_a),      64'd2);
    chk_val("t1_addr0", 64'(log_addr_a[0]), 64'h010);
    chk_val("t1_data0", 64'(log_data_a[0]), 64'h00000013);
    chk_val("t1_addr1", 64'(log_addr_a[1]), 64'h011);
    chk_val("t1_data1", 64'(log_data_a[1]), 64'h00000093);
    chk_val("t1_done",  64'(done_a),        64'h1);
    chk_val("t1_wcnt",  64'(wcnt_a),        64'd2);
    chk_val("t1_csum",  64'(csum_a),        64'hA6);
    chk_val("t1_err",   64'(err_a),         64'h0);
    // Bytes in DONE are ignored
    send(0, 8'h44);
    repeat (2) @(negedge clk);
    chk_val("t1_done_hold", 64'(done_a),   64'h1);
    chk_val("t1_no_wr",     64'(wr_cnt_a), 64'd2);
    pulse_clear_a();
    chk_val("t1_clr_done", 64'(done_a), 64'h0);
    chk_val("t1_clr_wcnt", 64'(wcnt_a), 64'd0);
    chk_val("t1_clr_csum", 64'(csum_a), 64'h0);
    chk_val("t1_clr_addr", 64'(addr_a), 64'h012);

    // Delayed grant: request held 6 cycles with stable address/data
    base_a = 14'h020;
    gnt_a  = 1'b0;
    start_wr = wr_cnt_a;
    send(0, 8'hAA); send(0, 8'hBB); send(0, 8'hCC); send(0, 8'hDD);
    for (int i = 0; i < 6; i++) begin
      chk_val("t3_we",   64'(we_a),    64'h1);
      chk_val("t3_addr", 64'(addr_a),  64'h020);
      chk_val("t3_data", 64'(wdata_a), 64'hDDCCBBAA);
      if (i == 5) begin
        gnt_a = 1'b1;
      end
      @(negedge clk);
    end
    gnt_a = 1'b0;
    chk_val("t3_we_off", 64'(we_a),     64'h0);
    chk_val("t3_addr+1", 64'(addr_a),   64'h021);
    chk_val("t3_wcnt",   64'(wcnt_a),   64'd1);
    chk_val("t3_csum",   64'(csum_a),   64'h0E);
    chk_val("t3_nwr",    64'(wr_cnt_a - start_wr), 64'd1);
    repeat (2) @(negedge clk);
    chk_val("t3_addr_once", 64'(addr_a), 64'h021);

    // Overrun: byte arrives while the write is still pending
    send(0, 8'h01); send(0, 8'h02); send(0, 8'h03); send(0, 8'h04);
    chk_val("t4_we_pend", 64'(we_a), 64'h1);
    send(0, 8'h77);
    chk_val("t4_err",   64'(err_a),   64'h1);
    chk_val("t4_cause", 64'(cause_a), 64'h1);
    chk_val("t4_we",    64'(we_a),    64'h0);
    chk_val("t4_wcnt",  64'(wcnt_a),  64'd1);
    chk_val("t4_nwr",   64'(wr_cnt_a - start_wr), 64'd1);
    pulse_clear_a();
    chk_val("t4_clr_err",   64'(err_a),   64'h0);
    chk_val("t4_clr_cause", 64'(cause_a), 64'h0);
    chk_val("t4_clr_wcnt",  64'(wcnt_a),  64'd0);
    chk_val("t4_clr_addr",  64'(addr_a),  64'h021);

    // Timeout discards a partial word without error
    base_a = 14'h030;
    gnt_a  = 1'b1;
    start_wr = wr_cnt_a;
    send(0, 8'h55); send(0, 8'h66);
    repeat (60) @(negedge clk);
    send(0, 8'h01); send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
    repeat (3) @(negedge clk);
    chk_val("t6_nwr",  64'(wr_cnt_a - start_wr), 64'd1);
    chk_val("t6_addr", 64'(log_addr_a[start_wr]), 64'h030);
    chk_val("t6_data", 64'(log_data_a[start_wr]), 64'h00000001);
    chk_val("t6_err",  64'(err_a),  64'h0);
    chk_val("t6_wcnt", 64'(wcnt_a), 64'd1);
    chk_val("t6_we",   64'(we_a),   64'h0);

    // MSB-first 16-bit words
    base_b = 14'h005;
    gnt_b  = 1'b1;
    send(1, 8'h12); send(1, 8'h34); send(1, 8'hFF); send(1, 8'hFF);
    repeat (3) @(negedge clk);
    chk_val("t2_nwr",  64'(wr_cnt_b),    64'd1);
    chk_val("t2_addr", 64'(last_addr_b), 64'h005);
    chk_val("t2_data", 64'(last_data_b), 64'h1234);
    chk_val("t2_done", 64'(done_b),      64'h1);
    chk_val("t2_wcnt", 64'(wcnt_b),      64'd1);
    chk_val("t2_csum", 64'(csum_b),      64'h46);
    chk_val("t2_err",  64'({err_b, cause_b}), 64'h0);

    // Address overflow at the top of a 4-bit space
    base_c = 4'hF;
    gnt_c  = 1'b1;
    send(2, 8'h78); send(2, 8'h56); send(2, 8'h34); send(2, 8'h12);
    repeat (3) @(negedge clk);
    chk_val("t5_nwr",   64'(wr_cnt_c),    64'd1);
    chk_val("t5_waddr", 64'(last_addr_c), 64'hF);
    chk_val("t5_wdata", 64'(last_data_c), 64'h12345678);
    chk_val("t5_err",   64'(err_c),       64'h1);
    chk_val("t5_cause", 64'(cause_c),     64'h2);
    chk_val("t5_wcnt",  64'(wcnt_c),      64'd1);
    chk_val("t5_addr",  64'(addr_c),      64'hF);
    chk_val("t5_we",    64'(we_c),        64'h0);
    chk_val("t5_csum",  64'(csum_c),      64'h14);
    chk_val("t5_done",  64'(done_c),      64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
